// File: rtl/ro_issue_stage_if.sv
// Decode -> issue -> execute bundle interface for the read-operands/issue stage.
// slave: the issue stage (consumes decode/RF/bypass, produces issue lanes).
// master: the surrounding pipeline (decode, register file, bypass network, execute).
interface ro_issue_stage_if #(
    parameter int LANES     = 2,
    parameter int XLEN      = 32,
    parameter int FWD_SRCS  = 6,
    parameter int PAYLOAD_W = 64
) ();
    logic                               flush;
    // decode side
    logic [LANES-1:0]                   in_valid;
    logic                               in_ready;
    logic [LANES-1:0]                   in_kill;
    logic [LANES-1:0][31:0]             in_pc;
    logic [LANES-1:0][4:0]              in_src1;
    logic [LANES-1:0][4:0]              in_src2;
    logic [LANES-1:0]                   in_src2_imm;
    logic [LANES-1:0][XLEN-1:0]         in_imm;
    logic [LANES-1:0][4:0]              in_dest;
    logic [LANES-1:0][PAYLOAD_W-1:0]    in_payload;
    // register file read ports: 2i = src1, 2i+1 = src2 of lane i
    logic [2*LANES-1:0][4:0]            rf_addr;
    logic [2*LANES-1:0][XLEN-1:0]       rf_data;
    // bypass network, index 0 youngest / highest priority
    logic [FWD_SRCS-1:0]                fwd_valid;
    logic [FWD_SRCS-1:0]                fwd_fwdable;
    logic [FWD_SRCS-1:0][4:0]           fwd_dest;
    logic [FWD_SRCS-1:0][XLEN-1:0]      fwd_result;
    // execute side
    logic [LANES-1:0]                   out_valid;
    logic                               out_ready;
    logic [LANES-1:0][31:0]             out_pc;
    logic [LANES-1:0][4:0]              out_dest;
    logic [LANES-1:0][PAYLOAD_W-1:0]    out_payload;
    logic [LANES-1:0][XLEN-1:0]         out_src1;
    logic [LANES-1:0][XLEN-1:0]         out_src2;
    logic [LANES-1:0][XLEN-1:0]         out_st_data;

    modport slave (
        input  flush, in_valid, in_kill, in_pc, in_src1, in_src2, in_src2_imm, in_imm,
               in_dest, in_payload, rf_data, fwd_valid, fwd_fwdable, fwd_dest, fwd_result,
               out_ready,
        output in_ready, rf_addr, out_valid, out_pc, out_dest, out_payload,
               out_src1, out_src2, out_st_data
    );

    modport master (
        output flush, in_valid, in_kill, in_pc, in_src1, in_src2, in_src2_imm, in_imm,
               in_dest, in_payload, rf_data, fwd_valid, fwd_fwdable, fwd_dest, fwd_result,
               out_ready,
        input  in_ready, rf_addr, out_valid, out_pc, out_dest, out_payload,
               out_src1, out_src2, out_st_data
    );
endinterface

// File: rtl/ro_issue_stage.sv
// Read-operands/issue stage: holds one decoded bundle, resolves operands (RF/bypass/capture), issues lanes in order.
// Latency: a bundle accepted on edge N can issue in the cycle after edge N at the earliest.
// Backpressure: in_ready only when every held lane leaves this cycle; out_ready=0 freezes issue, operands keep capturing.
// Ports: clk, reset (async active-low), bus (ro_issue_stage_if.slave: decode, RF read, bypass, execute).
// Optional: define RO_PERF_CNT_EN to add perf_raw_stall / perf_dep_stall saturating counters.
module ro_issue_stage #(
    parameter int LANES     = 2,
    parameter int XLEN      = 32,
    parameter int FWD_SRCS  = 6,
    parameter int PAYLOAD_W = 64
) (
    input  logic                clk,
    input  logic                reset,
    ro_issue_stage_if.slave     bus
`ifdef RO_PERF_CNT_EN
    ,
    output logic [31:0]         perf_raw_stall,
    output logic [31:0]         perf_dep_stall
`endif
);

    // held bundle
    logic [LANES-1:0]                   held_valid;
    logic [LANES-1:0][31:0]             pc_q;
    logic [LANES-1:0][4:0]              src1_q;
    logic [LANES-1:0][4:0]              src2_q;
    logic [LANES-1:0][4:0]              dest_q;
    logic [LANES-1:0]                   imm_sel_q;
    logic [LANES-1:0][XLEN-1:0]         imm_q;
    logic [LANES-1:0][PAYLOAD_W-1:0]    payload_q;
    // per-operand capture (operand 0 = src1, 1 = src2 register)
    logic [LANES-1:0][1:0]              cap_vld;
    logic [LANES-1:0][1:0][XLEN-1:0]    cap_dat;

    logic [LANES-1:0][1:0][4:0]         op_addr;
    logic [LANES-1:0][1:0][XLEN-1:0]    op_val;
    logic [LANES-1:0][1:0]              op_src_rdy;
    logic [LANES-1:0][1:0]              fwd_hit;
    logic [LANES-1:0][1:0]              op_dep;
    logic [LANES-1:0][1:0]              op_rdy;
    logic [LANES-1:0]                   lane_dep;
    logic [LANES-1:0]                   issue;
    logic [LANES:0]                     in_order;
    logic                               accept;

    // Operand resolution. Priority: r0, capture, first matching bypass entry, RF.
    always_comb begin
        op_addr    = '0;
        op_val     = '0;
        op_src_rdy = '0;
        fwd_hit    = '0;
        op_dep     = '0;
        for (int i = 0; i < LANES; i++) begin
            for (int o = 0; o < 2; o++) begin
                op_addr[i][o]    = (o == 0) ? src1_q[i] : src2_q[i];
                op_val[i][o]     = bus.rf_data[2*i+o];
                op_src_rdy[i][o] = 1'b1;
                // Only the highest-priority match counts, even if it is not yet forwardable.
                for (int k = 0; k < FWD_SRCS; k++) begin
                    if (!fwd_hit[i][o] && bus.fwd_valid[k] && bus.fwd_dest[k] == op_addr[i][o]) begin
                        fwd_hit[i][o]    = 1'b1;
                        op_src_rdy[i][o] = bus.fwd_fwdable[k];
                        op_val[i][o]     = bus.fwd_result[k];
                    end
                end
                if (cap_vld[i][o]) begin
                    op_src_rdy[i][o] = 1'b1;
                    op_val[i][o]     = cap_dat[i][o];
                end
                if (op_addr[i][o] == 5'd0) begin
                    op_src_rdy[i][o] = 1'b1;
                    op_val[i][o]     = '0;
                end
                // Producer sits in an older slot of this bundle: the RF value is stale
                // until that lane leaves and its result shows up on the bypass network.
                for (int j = 0; j < i; j++) begin
                    if (held_valid[j] && dest_q[j] != 5'd0 && dest_q[j] == op_addr[i][o])
                        op_dep[i][o] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            bus.rf_addr[2*i]   = src1_q[i];
            bus.rf_addr[2*i+1] = src2_q[i];
        end
    end

    // In-order issue: a lane may go only if every older slot is empty or issuing now.
    always_comb begin
        op_rdy      = op_src_rdy & ~op_dep;
        lane_dep    = '0;
        issue       = '0;
        in_order    = '0;
        in_order[0] = 1'b1;
        for (int i = 0; i < LANES; i++) begin
            lane_dep[i]   = |op_dep[i];
            issue[i]      = !bus.flush && bus.out_ready && held_valid[i] && (&op_rdy[i]) && in_order[i];
            in_order[i+1] = in_order[i] && (issue[i] || !held_valid[i]);
        end
    end

    assign bus.in_ready  = !bus.flush && in_order[LANES];
    assign accept        = bus.in_ready && (|bus.in_valid);
    assign bus.out_valid = issue;

    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            bus.out_pc[i]      = pc_q[i];
            bus.out_dest[i]    = dest_q[i];
            bus.out_payload[i] = payload_q[i];
            bus.out_src1[i]    = op_val[i][0];
            bus.out_st_data[i] = op_val[i][1];
            bus.out_src2[i]    = imm_sel_q[i] ? imm_q[i] : op_val[i][1];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            held_valid <= '0;
            cap_vld    <= '0;
        end else if (bus.flush) begin
            held_valid <= '0;
            cap_vld    <= '0;
        end else if (accept) begin
            held_valid <= bus.in_valid & ~bus.in_kill;
            cap_vld    <= '0;
        end else begin
            for (int i = 0; i < LANES; i++) begin
                if (issue[i]) begin
                    held_valid[i] <= 1'b0;
                end else if (held_valid[i]) begin
                    for (int o = 0; o < 2; o++) begin
                        if (op_rdy[i][o])
                            cap_vld[i][o] <= 1'b1;
                    end
                end
            end
        end
    end

    // Datapath registers: contents only matter while the matching valid/capture bit is set.
    always_ff @(posedge clk) begin
        if (accept) begin
            pc_q      <= bus.in_pc;
            src1_q    <= bus.in_src1;
            src2_q    <= bus.in_src2;
            dest_q    <= bus.in_dest;
            imm_sel_q <= bus.in_src2_imm;
            imm_q     <= bus.in_imm;
            payload_q <= bus.in_payload;
        end
        for (int i = 0; i < LANES; i++) begin
            for (int o = 0; o < 2; o++) begin
                if (held_valid[i] && !cap_vld[i][o])
                    cap_dat[i][o] <= op_val[i][o];
            end
        end
    end

`ifdef RO_PERF_CNT_EN
    logic raw_block;
    logic dep_block;

    always_comb begin
        raw_block = 1'b0;
        dep_block = 1'b0;
        // Walk downwards so the oldest held lane has the final say.
        for (int i = LANES - 1; i >= 0; i--) begin
            if (held_valid[i])
                raw_block = !(&op_src_rdy[i]);
        end
        for (int i = 0; i < LANES; i++) begin
            if (held_valid[i] && lane_dep[i] && (&op_src_rdy[i]))
                dep_block = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_raw_stall <= '0;
            perf_dep_stall <= '0;
        end else if (!bus.flush && bus.out_ready) begin
            if (raw_block && perf_raw_stall != 32'hFFFF_FFFF)
                perf_raw_stall <= perf_raw_stall + 32'd1;
            if (dep_block && perf_dep_stall != 32'hFFFF_FFFF)
                perf_dep_stall <= perf_dep_stall + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ro_issue_stage.sv
// Bench for ro_issue_stage: reset, table of single-lane operand-resolution vectors,
// hand-written multi-cycle sequences, then randomized traffic against a lane-record reference model.
module tb_ro_issue_stage;
    localparam int LANES = 2;
    localparam int XLEN  = 32;
    localparam int FWD   = 6;
    localparam int PW    = 64;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    ro_issue_stage_if #(.LANES(LANES), .XLEN(XLEN), .FWD_SRCS(FWD), .PAYLOAD_W(PW)) bus ();

`ifdef RO_PERF_CNT_EN
    logic [31:0] perf_raw_stall;
    logic [31:0] perf_dep_stall;
`endif

    ro_issue_stage #(.LANES(LANES), .XLEN(XLEN), .FWD_SRCS(FWD), .PAYLOAD_W(PW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef RO_PERF_CNT_EN
        ,
        .perf_raw_stall (perf_raw_stall),
        .perf_dep_stall (perf_dep_stall)
`endif
    );

    // Register file model answering the DUT's read addresses.
    logic [31:0] rf_mem [32];
    always_comb begin
        for (int p = 0; p < 2*LANES; p++)
            bus.rf_data[p] = rf_mem[bus.rf_addr[p]];
    end

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.flush       = 1'b0;
        bus.in_valid    = '0;
        bus.in_kill     = '0;
        bus.in_pc       = '0;
        bus.in_src1     = '0;
        bus.in_src2     = '0;
        bus.in_src2_imm = '0;
        bus.in_imm      = '0;
        bus.in_dest     = '0;
        bus.in_payload  = '0;
        bus.fwd_valid   = '0;
        bus.fwd_fwdable = '0;
        bus.fwd_dest    = '0;
        bus.fwd_result  = '0;
        bus.out_ready   = 1'b1;
    endtask

    // ---------------- table vectors ----------------
    typedef struct {
        logic [4:0]        s1, s2;
        logic              isel;
        logic [31:0]       imm;
        logic [5:0]        fv, ff;
        logic [5:0][4:0]   fd;
        logic [5:0][31:0]  fr;
        logic [1:0]        exp_ov;
        logic [31:0]       exp_s1, exp_s2, exp_st;
    } vec_t;
    localparam int NV = 8;
    vec_t tbl [NV];

    // ---------------- reference model ----------------
    bit          m_held [LANES];
    logic [31:0] m_pc   [LANES];
    logic [4:0]  m_src  [LANES][2];
    bit          m_isel [LANES];
    logic [31:0] m_imm  [LANES];
    logic [4:0]  m_dest [LANES];
    bit          m_cv   [LANES][2];
    logic [31:0] m_cval [LANES][2];

    // Value an operand would have now, from the spec's priority list.
    function automatic void operand(input int l, input int o, output bit rdy, output logic [31:0] v);
        logic [4:0] a;
        a = m_src[l][o];
        if (a == 5'd0) begin rdy = 1'b1; v = 32'd0; return; end
        if (m_cv[l][o]) begin rdy = 1'b1; v = m_cval[l][o]; return; end
        for (int k = 0; k < FWD; k++) begin
            if (bus.fwd_valid[k] && bus.fwd_dest[k] == a) begin
                rdy = bus.fwd_fwdable[k];
                v   = bus.fwd_result[k];
                return;
            end
        end
        rdy = 1'b1;
        v   = rf_mem[a];
    endfunction

    function automatic bit waits_on_elder(input int l, input int o);
        for (int j = 0; j < l; j++)
            if (m_held[j] && m_dest[j] != 5'd0 && m_dest[j] == m_src[l][o]) return 1'b1;
        return 1'b0;
    endfunction

    logic [1:0]  e_ov;
    bit          e_ok   [LANES][2];
    logic [31:0] e_val  [LANES][2];
    bit          e_wait [LANES][2];
    bit          older_gone;
    bit          e_in_ready;

    initial begin
        for (int r = 0; r < 32; r++) rf_mem[r] = 32'h100 + r;
        rf_mem[0] = 32'hDEAD_0000;
        rf_mem[1] = 32'd5;
        rf_mem[2] = 32'd7;
        rf_mem[3] = 32'h33;
        idle_inputs();

        // ---- reset ----
        reset = 1'b0;
        #12;
        check("reset_out_valid", 64'(bus.out_valid), 64'd0);
        check("reset_in_ready", 64'(bus.in_ready), 64'd1);
        @(negedge clk);
        reset = 1'b1;
        tick();

        // ---- table ----
        for (int v = 0; v < NV; v++) tbl[v] = '{default: '0};
        tbl[0].s1 = 1; tbl[0].s2 = 2; tbl[0].exp_ov = 2'b01;
        tbl[0].exp_s1 = 5; tbl[0].exp_s2 = 7; tbl[0].exp_st = 7;
        tbl[1].s1 = 4; tbl[1].s2 = 4; tbl[1].fv = 6'b001001; tbl[1].ff = 6'b001001;
        tbl[1].fd[0] = 4; tbl[1].fr[0] = 32'hAA; tbl[1].fd[3] = 4; tbl[1].fr[3] = 32'hBB;
        tbl[1].exp_ov = 2'b01; tbl[1].exp_s1 = 32'hAA; tbl[1].exp_s2 = 32'hAA; tbl[1].exp_st = 32'hAA;
        tbl[2].s1 = 0; tbl[2].s2 = 4; tbl[2].isel = 1; tbl[2].imm = 32'h123;
        tbl[2].fv = 6'b001000; tbl[2].ff = 6'b001001; tbl[2].fd[0] = 4; tbl[2].fr[0] = 32'hAA;
        tbl[2].fd[3] = 4; tbl[2].fr[3] = 32'hBB;
        tbl[2].exp_ov = 2'b01; tbl[2].exp_s1 = 0; tbl[2].exp_s2 = 32'h123; tbl[2].exp_st = 32'hBB;
        tbl[3].s1 = 4; tbl[3].s2 = 3; tbl[3].fv = 6'b000011; tbl[3].ff = 6'b000010;
        tbl[3].fd[0] = 4; tbl[3].fd[1] = 4; tbl[3].fr[1] = 32'hCC; tbl[3].exp_ov = 2'b00;
        tbl[4].s1 = 9; tbl[4].s2 = 3; tbl[4].fv = 6'b100000; tbl[4].ff = 6'b100000;
        tbl[4].fd[5] = 9; tbl[4].fr[5] = 32'h55;
        tbl[4].exp_ov = 2'b01; tbl[4].exp_s1 = 32'h55; tbl[4].exp_s2 = 32'h33; tbl[4].exp_st = 32'h33;
        tbl[5].fv = 6'b000001; tbl[5].ff = 6'b000001; tbl[5].fd[0] = 0; tbl[5].fr[0] = 32'h77;
        tbl[5].exp_ov = 2'b01;
        tbl[6].s1 = 7; tbl[6].s2 = 5; tbl[6].fv = 6'b000100; tbl[6].fd[2] = 8;
        tbl[6].exp_ov = 2'b01; tbl[6].exp_s1 = 32'h107; tbl[6].exp_s2 = 32'h105; tbl[6].exp_st = 32'h105;
        tbl[7].s1 = 6; tbl[7].s2 = 6; tbl[7].fv = 6'b010010; tbl[7].ff = 6'b000010;
        tbl[7].fd[1] = 6; tbl[7].fr[1] = 32'h66; tbl[7].fd[4] = 6; tbl[7].fr[4] = 32'h44;
        tbl[7].exp_ov = 2'b01; tbl[7].exp_s1 = 32'h66; tbl[7].exp_s2 = 32'h66; tbl[7].exp_st = 32'h66;

        for (int v = 0; v < NV; v++) begin
            idle_inputs();
            bus.in_valid       = 2'b01;
            bus.in_src1[0]     = tbl[v].s1;
            bus.in_src2[0]     = tbl[v].s2;
            bus.in_src2_imm[0] = tbl[v].isel;
            bus.in_imm[0]      = tbl[v].imm;
            bus.in_dest[0]     = 5'd20;
            bus.fwd_valid      = tbl[v].fv;
            bus.fwd_fwdable    = tbl[v].ff;
            for (int k = 0; k < FWD; k++) begin
                bus.fwd_dest[k]   = tbl[v].fd[k];
                bus.fwd_result[k] = tbl[v].fr[k];
            end
            tick();
            bus.in_valid = '0;
            @(negedge clk);
            check($sformatf("v%0d_out_valid", v), 64'(bus.out_valid), 64'(tbl[v].exp_ov));
            check($sformatf("v%0d_in_ready", v), 64'(bus.in_ready), 64'(tbl[v].exp_ov[0]));
            if (tbl[v].exp_ov[0]) begin
                check($sformatf("v%0d_src1", v), 64'(bus.out_src1[0]), 64'(tbl[v].exp_s1));
                check($sformatf("v%0d_src2", v), 64'(bus.out_src2[0]), 64'(tbl[v].exp_s2));
                check($sformatf("v%0d_st_data", v), 64'(bus.out_st_data[0]), 64'(tbl[v].exp_st));
            end
            tick();
            bus.flush = 1'b1;
            tick();
            bus.flush = 1'b0;
        end

        // ---- producer not forwardable for two cycles ----
        idle_inputs();
        bus.in_valid = 2'b01; bus.in_src1[0] = 4; bus.in_dest[0] = 1;
        bus.fwd_valid = 6'b000001; bus.fwd_dest[0] = 4;
        tick();
        bus.in_valid = '0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            check($sformatf("nf_stall%0d_ov", c), 64'(bus.out_valid), 64'd0);
            check($sformatf("nf_stall%0d_in_ready", c), 64'(bus.in_ready), 64'd0);
            tick();
        end
        bus.fwd_fwdable = 6'b000001; bus.fwd_result[0] = 32'h10;
        @(negedge clk);
        check("nf_issue_ov", 64'(bus.out_valid), 64'b01);
        check("nf_issue_src1", 64'(bus.out_src1[0]), 64'h10);
        check("nf_issue_in_ready", 64'(bus.in_ready), 64'd1);
        tick();

        // ---- intra-bundle RAW ----
        idle_inputs();
        bus.in_valid = 2'b11;
        bus.in_src1[0] = 1; bus.in_src2[0] = 2; bus.in_dest[0] = 5;
        bus.in_src1[1] = 5; bus.in_src2[1] = 0; bus.in_dest[1] = 6;
        tick();
        bus.in_valid = '0;
        @(negedge clk);
        check("raw_c1_ov", 64'(bus.out_valid), 64'b01);
        check("raw_c1_in_ready", 64'(bus.in_ready), 64'd0);
        tick();
        bus.fwd_valid = 6'b000001; bus.fwd_fwdable = 6'b000001;
        bus.fwd_dest[0] = 5; bus.fwd_result[0] = 32'h99;
        @(negedge clk);
        check("raw_c2_ov", 64'(bus.out_valid), 64'b10);
        check("raw_c2_src1", 64'(bus.out_src1[1]), 64'h99);
        check("raw_c2_in_ready", 64'(bus.in_ready), 64'd1);
        tick();

        // ---- capture survives a stall while RF changes ----
        idle_inputs();
        rf_mem[6] = 32'h1;
        bus.out_ready = 1'b0;
        bus.in_valid = 2'b01; bus.in_src1[0] = 6; bus.in_dest[0] = 7;
        bus.in_pc[0] = 32'h4000; bus.in_payload[0] = 64'hCAFE_F00D_1234_5678;
        tick();
        bus.in_valid = '0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check($sformatf("cap_stall%0d_ov", c), 64'(bus.out_valid), 64'd0);
            tick();
            rf_mem[6] = 32'h2;
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("cap_issue_ov", 64'(bus.out_valid), 64'b01);
        check("cap_issue_src1", 64'(bus.out_src1[0]), 64'h1);
        check("cap_issue_pc", 64'(bus.out_pc[0]), 64'h4000);
        check("cap_issue_payload", bus.out_payload[0], 64'hCAFE_F00D_1234_5678);
        tick();

        // ---- flush with both lanes held and a new bundle offered ----
        idle_inputs();
        bus.out_ready = 1'b0;
        bus.in_valid = 2'b11;
        tick();
        bus.in_valid = '0;
        tick();
        bus.flush = 1'b1; bus.in_valid = 2'b11; bus.out_ready = 1'b1;
        @(negedge clk);
        check("flush_ov", 64'(bus.out_valid), 64'd0);
        tick();
        bus.flush = 1'b0; bus.in_valid = '0;
        @(negedge clk);
        check("post_flush_ov", 64'(bus.out_valid), 64'd0);
        check("post_flush_in_ready", 64'(bus.in_ready), 64'd1);
        tick();

        // ---- kill at accept ----
        idle_inputs();
        bus.in_valid = 2'b11; bus.in_kill = 2'b10;
        tick();
        bus.in_valid = '0; bus.in_kill = '0;
        @(negedge clk);
        check("kill_ov", 64'(bus.out_valid), 64'b01);
        tick();

        // ---- asynchronous reset while stalled ----
        idle_inputs();
        bus.out_ready = 1'b0;
        bus.in_valid = 2'b01; bus.in_src1[0] = 3;
        tick();
        bus.in_valid = '0;
        #2;
        check("stall_in_ready", 64'(bus.in_ready), 64'd0);
        reset = 1'b0;
        #1;
        check("async_rst_in_ready", 64'(bus.in_ready), 64'd1);
        bus.out_ready = 1'b1;
        #1;
        check("async_rst_ov", 64'(bus.out_valid), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        tick();

        // ---- randomized traffic against the model ----
        idle_inputs();
        for (int l = 0; l < LANES; l++) begin
            m_held[l] = 1'b0;
            m_cv[l][0] = 1'b0;
            m_cv[l][1] = 1'b0;
        end
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(posedge clk);
            #1;
            bus.flush     = ($urandom_range(0, 19) == 0);
            bus.out_ready = ($urandom_range(0, 4) != 0);
            bus.in_valid  = 2'($urandom_range(0, 3));
            for (int l = 0; l < LANES; l++) begin
                bus.in_kill[l]     = ($urandom_range(0, 4) == 0);
                bus.in_pc[l]       = $urandom;
                bus.in_src1[l]     = 5'($urandom_range(0, 7));
                bus.in_src2[l]     = 5'($urandom_range(0, 7));
                bus.in_src2_imm[l] = 1'($urandom_range(0, 1));
                bus.in_imm[l]      = $urandom;
                bus.in_dest[l]     = 5'($urandom_range(0, 7));
                bus.in_payload[l]  = {$urandom, $urandom};
            end
            for (int k = 0; k < FWD; k++) begin
                bus.fwd_valid[k]   = 1'($urandom_range(0, 1));
                bus.fwd_fwdable[k] = ($urandom_range(0, 9) < 7);
                bus.fwd_dest[k]    = 5'($urandom_range(0, 7));
                bus.fwd_result[k]  = $urandom;
            end
            rf_mem[$urandom_range(1, 7)] = $urandom;
            @(negedge clk);

            e_ov = '0;
            older_gone = 1'b1;
            for (int l = 0; l < LANES; l++) begin
                for (int o = 0; o < 2; o++) begin
                    operand(l, o, e_ok[l][o], e_val[l][o]);
                    e_wait[l][o] = waits_on_elder(l, o);
                end
                if (m_held[l]) begin
                    if (older_gone && !bus.flush && bus.out_ready &&
                        e_ok[l][0] && e_ok[l][1] && !e_wait[l][0] && !e_wait[l][1])
                        e_ov[l] = 1'b1;
                    else
                        older_gone = 1'b0;
                end
            end
            e_in_ready = !bus.flush && older_gone;

            check("rnd_out_valid", 64'(bus.out_valid), 64'(e_ov));
            check("rnd_in_ready", 64'(bus.in_ready), 64'(e_in_ready));
            for (int l = 0; l < LANES; l++) begin
                if (e_ov[l]) begin
                    check($sformatf("rnd_l%0d_src1", l), 64'(bus.out_src1[l]), 64'(e_val[l][0]));
                    check($sformatf("rnd_l%0d_src2", l), 64'(bus.out_src2[l]),
                          64'(m_isel[l] ? m_imm[l] : e_val[l][1]));
                    check($sformatf("rnd_l%0d_st", l), 64'(bus.out_st_data[l]), 64'(e_val[l][1]));
                    check($sformatf("rnd_l%0d_pc", l), 64'(bus.out_pc[l]), 64'(m_pc[l]));
                end
            end

            if (bus.flush) begin
                for (int l = 0; l < LANES; l++) begin
                    m_held[l] = 1'b0; m_cv[l][0] = 1'b0; m_cv[l][1] = 1'b0;
                end
            end else if (e_in_ready && bus.in_valid != 2'b00) begin
                for (int l = 0; l < LANES; l++) begin
                    m_held[l]   = bus.in_valid[l] && !bus.in_kill[l];
                    m_pc[l]     = bus.in_pc[l];
                    m_src[l][0] = bus.in_src1[l];
                    m_src[l][1] = bus.in_src2[l];
                    m_isel[l]   = bus.in_src2_imm[l];
                    m_imm[l]    = bus.in_imm[l];
                    m_dest[l]   = bus.in_dest[l];
                    m_cv[l][0]  = 1'b0;
                    m_cv[l][1]  = 1'b0;
                end
            end else begin
                for (int l = 0; l < LANES; l++) begin
                    if (e_ov[l]) begin
                        m_held[l] = 1'b0;
                    end else if (m_held[l]) begin
                        for (int o = 0; o < 2; o++) begin
                            if (!m_cv[l][o] && e_ok[l][o] && !e_wait[l][o]) begin
                                m_cv[l][o]   = 1'b1;
                                m_cval[l][o] = e_val[l][o];
                            end
                        end
                    end
                end
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
